main_fsm: RTL
=============

# main_fsm

Multicycle control unit for the RV64I core. Decodes the 7-bit opcode and walks each instruction through fetch, decode, execute, memory and writeback. In every state it drives the ALU operation class consumed by the ALU decoder, the datapath mux selects and the write enables. It also sequences the variable-latency memory handshake and raises a one-cycle trap on illegal instructions.

## Interface

**Parameters**
- `RESET_STATE`, default `FETCH`: state entered on reset; exists for bench bring-up only.

**Ports**
- `i_clk` — in, 1: core clock.
- `i_arstn` — in, 1: asynchronous active-low reset.
- `i_op` — in, 7: `instr[6:0]` from the instruction register.
- `i_illegal_instr` — in, 1: illegal flag from the ALU decoder, valid combinationally in execute states.
- `i_mem_done` — in, 1: memory/cache completion; one-cycle pulse, any latency ≥ 1.
- `o_alu_op` — out, 3: operation class. `000` add, `001` sub/branch, `010` I/R, `011` I/R-W, `100` CSR.
- `o_alu_src_a` — out, 2: `00` PC, `01` old PC, `10` rs1.
- `o_alu_src_b` — out, 2: `00` rs2, `01` immediate, `10` constant 4.
- `o_result_src` — out, 2: `00` ALU-out register, `01` memory read data, `10` ALU result, `11` CSR read data.
- `o_addr_src` — out, 1: `0` PC, `1` ALU-out (data address).
- `o_mem_req` — out, 1: memory request, held until `i_mem_done`.
- `o_mem_write` — out, 1: request is a store.
- `o_instr_write`, `o_pc_write`, `o_reg_write`, `o_csr_write`, `o_branch`, `o_trap` — out, 1 each: enables and pulses.

## Operation

**States and transitions.**
- **FETCH**
  - `o_mem_req=1`, `addr_src=0`, `alu_op=000`, `src_a=00`, `src_b=10`.
  - Waits for `i_mem_done`, then goes to DECODE.
- **DECODE**
  - `alu_op=000`, `src_a=01`, `src_b=01` (branch target precompute).
  - Dispatches on `i_op`:
    - `0000011`, `0100011` → MEMADDR
    - `0110011` → EXECUTER
    - `0010011` → EXECUTEI
    - `0111011`, `0011011` → EXECUTEW
    - `1100011` → BRANCH
    - `1101111` → JAL
    - `1100111` → JALR
    - `0110111` → LUI
    - `0010111` → AUIPC
    - `1110011` → CSR
    - anything else → TRAP
- **MEMADDR**: `alu_op=000`, `src_a=10`, `src_b=01`. Load → MEMREAD; store → MEMWRITE.
- **MEMREAD**: `mem_req=1`, `addr_src=1`; on `i_mem_done` → MEMWB.
- **MEMWB**: `result_src=01`, `reg_write=1` → FETCH.
- **MEMWRITE**: `mem_req=1`, `mem_write=1`, `addr_src=1`; on `i_mem_done` → FETCH.
- **EXECUTER / EXECUTEI / EXECUTEW**
  - `src_a=10`; `src_b` is `00` for R forms, `01` for I forms.
  - `alu_op` is `010`, `010`, `011` respectively.
  - Next state: ALUWB, or TRAP if `i_illegal_instr`.
- **ALUWB**: `result_src=00`, `reg_write=1` → FETCH.
- **BRANCH**: `alu_op=001`, `src_a=10`, `src_b=00`, `branch=1`, `result_src=00` → FETCH.
- **JAL**: `src_a=01`, `src_b=10`, `pc_write=1`, `result_src=00` → ALUWB.
- **JALR**: `src_a=10`, `src_b=01` → JAL.
- **LUI**: `src_b=01`, `src_a` don't-care → ALUWB, with `alu_op=000` on an immediate-only path.
- **AUIPC**: `src_a=01`, `src_b=01` → ALUWB.
- **CSR**: `alu_op=100`, `result_src=11`, `reg_write=1`, `csr_write=1`. Goes to FETCH, or to TRAP if `i_illegal_instr`; in that case `reg_write` and `csr_write` are forced to 0.
- **TRAP**: `o_trap=1` for exactly one cycle → FETCH.

**Output rules.**
- All outputs not listed for a state are 0.
- `o_instr_write` and `o_pc_write` in FETCH are Mealy outputs: `= i_mem_done`.
- All other outputs are Moore outputs.
- An `i_mem_done` arriving outside FETCH, MEMREAD or MEMWRITE is ignored.

## Timing

- **Reset:** asynchronous on `i_arstn` low. State goes to FETCH and every output reads 0, except FETCH Moore values (`mem_req=1`, `src_b=10`), which appear after reset release.
- **Cycle counts** (excluding memory wait):
  - load: 5
  - store: 4
  - R/I/W: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - lui/auipc: 4
  - CSR: 3
  - trap: 3
- **Memory wait:** each memory state adds N−1 cycles for `i_mem_done` arriving N cycles after entry. With `i_mem_done=1` on the first cycle, there are zero wait states.
- **Request hold:** `o_mem_req` stays asserted and address selects stay stable until the `i_mem_done` cycle inclusive. The request deasserts the cycle after.
- **Reset mid-request:** FSM returns to FETCH. A stale `i_mem_done` in FETCH's first cycle is accepted as completion; the memory side must be reset together with the FSM.
- `i_illegal_instr` is sampled only in execute and CSR states.

## Configuration

- **`MAIN_FSM_CSR_EN`**
  - Defined: the CSR state exists as above.
  - Undefined: opcode `1110011` decodes to TRAP, `o_csr_write` is tied 0, and `alu_op=100` is never produced.

## Test plan

- **Reset and fetch:** hold `i_arstn=0` → all outputs 0. Release, with `i_mem_done` arriving on the 3rd FETCH cycle → `o_instr_write` and `o_pc_write` high in exactly that cycle, then DECODE.
- **ADD:** `i_op=0110011`, zero-wait memory → `alu_op=010` in cycle 3, `reg_write=1` with `result_src=00` in cycle 4, back in FETCH in cycle 5.
- **Load with 4-cycle memory wait:** `i_op=0000011` → `o_mem_req` with `addr_src=1` held 4 cycles, then MEMWB with `result_src=01` and `reg_write=1`.
- **Branch:** `i_op=1100011` → `alu_op=001` and `o_branch=1` for one cycle, no `reg_write`, then FETCH.
- **Illegal instructions:**
  - `i_op=0000000` → TRAP after DECODE, `o_trap` high for one cycle.
  - `i_op=0111011` with `i_illegal_instr=1` → TRAP, with no `reg_write`.
- **CSR:** `i_op=1110011` → with the macro defined, `alu_op=100` and `csr_write=1`; without it, `o_trap=1`.

Source files
------------

// File: rtl/main_fsm.sv
// Multicycle control FSM for the RV64I core.
// Walks each instruction through fetch/decode/execute/memory/writeback and drives
// ALU class, datapath mux selects, write enables, the memory handshake and the trap pulse.
// Optional CSR support is compiled in when MAIN_FSM_CSR_EN is defined; without it the
// SYSTEM opcode traps and o_csr_write is tied low.
module main_fsm #(
  // State entered on reset, as the raw state encoding (0 = fetch); bench bring-up only.
  parameter logic [4:0] RESET_STATE = 5'd0
) (
  input  logic       i_clk,
  input  logic       i_arstn,
  input  logic [6:0] i_op,
  input  logic       i_illegal_instr,
  input  logic       i_mem_done,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic       o_addr_src,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_instr_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_csr_write,
  output logic       o_branch,
  output logic       o_trap
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpRW     = 7'b0111011;
  localparam logic [6:0] OpIW     = 7'b0011011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [4:0] {
    StFetch    = 5'd0,
    StDecode   = 5'd1,
    StMemAddr  = 5'd2,
    StMemRead  = 5'd3,
    StMemWb    = 5'd4,
    StMemWrite = 5'd5,
    StExecR    = 5'd6,
    StExecI    = 5'd7,
    StExecW    = 5'd8,
    StAluWb    = 5'd9,
    StBranch   = 5'd10,
    StJal      = 5'd11,
    StJalr     = 5'd12,
    StLui      = 5'd13,
    StAuipc    = 5'd14,
    StCsr      = 5'd15,
    StTrap     = 5'd16
  } state_t;

  state_t state_q, state_d;

  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       addr_src;
  logic       mem_req;
  logic       mem_write;
  logic       instr_write;
  logic       pc_write;
  logic       reg_write;
  logic       csr_write;
  logic       branch;
  logic       trap;

  // State register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; outputs default to 0 and are blanked while in reset.
  always_comb begin
    state_d     = state_q;
    alu_op      = 3'b000;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    addr_src    = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    instr_write = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    csr_write   = 1'b0;
    branch      = 1'b0;
    trap        = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        // PC+4 and IR capture happen on the completion cycle itself.
        instr_write = i_mem_done;
        pc_write    = i_mem_done;
        if (i_mem_done) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch/jump target into the ALU-out register.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (i_op)
          OpLoad, OpStore: state_d = StMemAddr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpRW, OpIW:      state_d = StExecW;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
`ifdef MAIN_FSM_CSR_EN
          OpSystem:        state_d = StCsr;
`else
          OpSystem:        state_d = StTrap;
`endif
          default:         state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (i_op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (i_mem_done) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        addr_src  = 1'b1;
        if (i_mem_done) state_d = StFetch;
      end
      StExecR: begin
        alu_op    = 3'b010;
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        state_d   = i_illegal_instr ? StTrap : StAluWb;
      end
      StExecI: begin
        alu_op    = 3'b010;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = i_illegal_instr ? StTrap : StAluWb;
      end
      StExecW: begin
        alu_op    = 3'b011;
        alu_src_a = 2'b10;
        // Opcode bit 5 separates OP-32 (register) from OP-IMM-32 (immediate).
        alu_src_b = i_op[5] ? 2'b00 : 2'b01;
        state_d   = i_illegal_instr ? StTrap : StAluWb;
      end
      StAluWb: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_op    = 3'b001;
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        branch    = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        // Link value old PC + 4 computed while the target loads into PC from ALU-out.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StJalr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = StJal;
      end
      StLui: begin
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
      StAuipc: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
`ifdef MAIN_FSM_CSR_EN
      StCsr: begin
        alu_op     = 3'b100;
        result_src = 2'b11;
        if (i_illegal_instr) begin
          state_d = StTrap;
        end else begin
          reg_write = 1'b1;
          csr_write = 1'b1;
          state_d   = StFetch;
        end
      end
`endif
      StTrap: begin
        trap    = 1'b1;
        state_d = StFetch;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

`ifndef MAIN_FSM_CSR_EN
    csr_write = 1'b0;
`endif

    // Fetch's Moore values must not be visible until reset is released.
    if (!i_arstn) begin
      alu_op      = 3'b000;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      addr_src    = 1'b0;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      instr_write = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      csr_write   = 1'b0;
      branch      = 1'b0;
      trap        = 1'b0;
    end
  end

  assign o_alu_op      = alu_op;
  assign o_alu_src_a   = alu_src_a;
  assign o_alu_src_b   = alu_src_b;
  assign o_result_src  = result_src;
  assign o_addr_src    = addr_src;
  assign o_mem_req     = mem_req;
  assign o_mem_write   = mem_write;
  assign o_instr_write = instr_write;
  assign o_pc_write    = pc_write;
  assign o_reg_write   = reg_write;
  assign o_csr_write   = csr_write;
  assign o_branch      = branch;
  assign o_trap        = trap;

endmodule
